// File: rtl/program_loader.sv
// program_loader: receives a length-prefixed byte stream from a host and writes
// it as little-endian 32-bit words into instruction memory, holding the CPU
// while a load is in progress or has failed.
//
// Ports:
//   clock      sole clock, rising edge
//   reset      synchronous active-low reset
//   start      one-cycle request to begin a load frame (IDLE/DONE/ERR only)
//   in_data    host byte stream
//   in_valid   in_data valid
//   in_ready   byte accepted on in_valid & in_ready
//   mem_addr   instruction-memory word address
//   mem_data   instruction word
//   mem_write  one-cycle write strobe per word
//   cpu_hold   CPU held (load in progress or failed)
//   busy       receiving or writing
//   done       load completed
//   error      word count exceeded memory capacity
module program_loader #(
    parameter int unsigned ADDR_W = 10
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_data,
    output logic              mem_write,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              error
);

    localparam int unsigned CAPACITY = 2 ** ADDR_W;
    // One extra bit so a full-capacity count can be represented.
    localparam int unsigned CNT_W    = ADDR_W + 1;

    typedef enum logic [2:0] {
        IDLE, LEN_LO, LEN_HI, DATA, WRITE, DONE, ERR
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [15:0]      len;
    logic [1:0]       byte_cnt;
    logic [23:0]      word_buf;
    logic [CNT_W-1:0] word_cnt;

    logic             hs;
    logic [15:0]      len_full;
    logic [CNT_W-1:0] word_cnt_inc;

    assign hs           = in_valid & in_ready;
    assign len_full     = {in_data, len[7:0]};
    assign word_cnt_inc = word_cnt + CNT_W'(1);

    // Next-state decode.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE, DONE, ERR: if (start) state_nx = LEN_LO;
            LEN_LO:          if (hs) state_nx = LEN_HI;
            LEN_HI: begin
                if (hs) begin
                    if (len_full == 16'd0)                 state_nx = DONE;
                    else if (32'(len_full) > CAPACITY)     state_nx = ERR;
                    else                                   state_nx = DATA;
                end
            end
            DATA:            if (hs && byte_cnt == 2'd3) state_nx = WRITE;
            WRITE:           state_nx = (32'(word_cnt_inc) == 32'(len)) ? DONE : DATA;
            default:         state_nx = IDLE;
        endcase
    end

    // State, datapath and registered outputs.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state     <= IDLE;
            len       <= 16'd0;
            byte_cnt  <= 2'd0;
            word_buf  <= 24'd0;
            word_cnt  <= '0;
            mem_addr  <= '0;
            mem_data  <= 32'd0;
            mem_write <= 1'b0;
            in_ready  <= 1'b0;
            cpu_hold  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE, DONE, ERR: begin
                    if (start) begin
                        byte_cnt <= 2'd0;
                        word_cnt <= '0;
                    end
                end
                LEN_LO: if (hs) len[7:0]  <= in_data;
                LEN_HI: if (hs) len[15:8] <= in_data;
                DATA: begin
                    if (hs) begin
                        byte_cnt <= byte_cnt + 2'd1;
                        case (byte_cnt)
                            2'd0:    word_buf[7:0]   <= in_data;
                            2'd1:    word_buf[15:8]  <= in_data;
                            2'd2:    word_buf[23:16] <= in_data;
                            default: begin
                                // Fourth byte goes straight to the output word.
                                mem_addr <= word_cnt[ADDR_W-1:0];
                                mem_data <= {in_data, word_buf};
                            end
                        endcase
                    end
                end
                WRITE:   word_cnt <= word_cnt_inc;
                default: ;
            endcase

            mem_write <= (state_nx == WRITE);
            in_ready  <= (state_nx inside {LEN_LO, LEN_HI, DATA});
            busy      <= (state_nx inside {LEN_LO, LEN_HI, DATA, WRITE});
            cpu_hold  <= (state_nx inside {LEN_LO, LEN_HI, DATA, WRITE, ERR});
            done      <= (state_nx == DONE);
            error     <= (state_nx == ERR);
        end
    end

endmodule

// File: tb/tb_program_loader.sv
module tb_program_loader;

    localparam int unsigned ADDR_W = 10;

    logic              clock    = 1'b0;
    logic              reset    = 1'b0;
    logic              start    = 1'b0;
    logic [7:0]        in_data  = 8'd0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_data;
    logic              mem_write;
    logic              cpu_hold;
    logic              busy;
    logic              done;
    logic              error;

    int total = 0;
    int bad   = 0;
    int wr_n  = 0;
    logic [ADDR_W-1:0] wr_last_addr = '0;

    program_loader #(.ADDR_W(ADDR_W)) dut (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .mem_addr (mem_addr),
        .mem_data (mem_data),
        .mem_write(mem_write),
        .cpu_hold (cpu_hold),
        .busy     (busy),
        .done     (done),
        .error    (error)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (mem_write) begin
            wr_n         <= wr_n + 1;
            wr_last_addr <= mem_addr;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Offer one byte and wait (bounded) for it to be accepted; returns just after a negedge.
    task automatic send_byte(input logic [7:0] b);
        int t;
        t = 0;
        in_data  = b;
        in_valid = 1'b1;
        while (!in_ready && t < 40) begin
            @(negedge clock);
            t++;
        end
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL handshake_timeout: in_ready=%b required 1 for byte %h", in_ready, b);
        end
        @(negedge clock);
        in_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        send_byte(w[7:0]);
        send_byte(w[15:8]);
        send_byte(w[23:16]);
        send_byte(w[31:24]);
    endtask

    task automatic pulse_start;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b0;
        repeat (2) @(negedge clock);
        total++; if ({in_ready, mem_write, cpu_hold, busy, done, error} !== 6'd0) begin bad++; $display("FAIL reset_flags: got %b required 000000", {in_ready, mem_write, cpu_hold, busy, done, error}); end
        total++; if (mem_addr !== '0) begin bad++; $display("FAIL reset_addr: got %h required 0", mem_addr); end
        total++; if (mem_data !== 32'd0) begin bad++; $display("FAIL reset_data: got %h required 0", mem_data); end
        reset = 1'b1;
        @(negedge clock);
        total++; if ({in_ready, busy, cpu_hold} !== 3'b000) begin bad++; $display("FAIL idle_flags: got %b required 000", {in_ready, busy, cpu_hold}); end
    endtask

    task automatic test_basic;
        int w0;
        w0 = wr_n;
        pulse_start;
        total++; if ({in_ready, busy, cpu_hold, done} !== 4'b1110) begin bad++; $display("FAIL basic_len_lo: got %b required 1110", {in_ready, busy, cpu_hold, done}); end
        send_byte(8'h02);
        send_byte(8'h00);
        send_word(32'h91000013);
        total++; if (mem_write !== 1'b1) begin bad++; $display("FAIL basic_w0_strobe: got %b required 1", mem_write); end
        total++; if (mem_addr !== 10'h000) begin bad++; $display("FAIL basic_w0_addr: got %h required 000", mem_addr); end
        total++; if (mem_data !== 32'h91000013) begin bad++; $display("FAIL basic_w0_data: got %h required 91000013", mem_data); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL basic_write_ready: got %b required 0", in_ready); end
        send_word(32'hD61F0000);
        total++; if (mem_write !== 1'b1) begin bad++; $display("FAIL basic_w1_strobe: got %b required 1", mem_write); end
        total++; if (mem_addr !== 10'h001) begin bad++; $display("FAIL basic_w1_addr: got %h required 001", mem_addr); end
        total++; if (mem_data !== 32'hD61F0000) begin bad++; $display("FAIL basic_w1_data: got %h required d61f0000", mem_data); end
        @(negedge clock);
        total++; if ({done, cpu_hold, busy, mem_write} !== 4'b1000) begin bad++; $display("FAIL basic_done: got %b required 1000", {done, cpu_hold, busy, mem_write}); end
        total++; if (wr_n - w0 !== 2) begin bad++; $display("FAIL basic_write_count: got %0d required 2", wr_n - w0); end
        total++; if (mem_addr !== 10'h001) begin bad++; $display("FAIL basic_addr_hold: got %h required 001", mem_addr); end
    endtask

    task automatic test_zero_len;
        int w0;
        w0 = wr_n;
        pulse_start;
        total++; if (done !== 1'b0) begin bad++; $display("FAIL zero_done_cleared: got %b required 0", done); end
        send_byte(8'h00);
        total++; if ({cpu_hold, busy} !== 2'b11) begin bad++; $display("FAIL zero_hold_len: got %b required 11", {cpu_hold, busy}); end
        send_byte(8'h00);
        total++; if ({done, cpu_hold, busy, in_ready} !== 4'b1000) begin bad++; $display("FAIL zero_done: got %b required 1000", {done, cpu_hold, busy, in_ready}); end
        total++; if (wr_n - w0 !== 0) begin bad++; $display("FAIL zero_no_write: got %0d required 0", wr_n - w0); end
    endtask

    task automatic test_overflow;
        int w0;
        w0 = wr_n;
        pulse_start;
        send_byte(8'h01);
        send_byte(8'h04);
        total++; if ({error, cpu_hold, in_ready, busy, done} !== 5'b11000) begin bad++; $display("FAIL ovf_err: got %b required 11000", {error, cpu_hold, in_ready, busy, done}); end
        in_data  = 8'h55;
        in_valid = 1'b1;
        repeat (3) @(negedge clock);
        in_valid = 1'b0;
        total++; if ({error, in_ready} !== 2'b10) begin bad++; $display("FAIL ovf_persist: got %b required 10", {error, in_ready}); end
        total++; if (wr_n - w0 !== 0) begin bad++; $display("FAIL ovf_no_write: got %0d required 0", wr_n - w0); end
        pulse_start;
        total++; if ({error, in_ready, busy} !== 3'b011) begin bad++; $display("FAIL ovf_restart: got %b required 011", {error, in_ready, busy}); end
        send_byte(8'h00);
        send_byte(8'h00);
        total++; if (done !== 1'b1) begin bad++; $display("FAIL ovf_restart_done: got %b required 1", done); end
    endtask

    task automatic test_stall;
        int w0;
        w0 = wr_n;
        pulse_start;
        send_byte(8'h01);
        send_byte(8'h00);
        send_byte(8'hAA);
        @(negedge clock);
        send_byte(8'hBB);
        @(negedge clock);
        pulse_start;
        total++; if ({in_ready, busy, done} !== 3'b110) begin bad++; $display("FAIL stall_start_ignored: got %b required 110", {in_ready, busy, done}); end
        send_byte(8'hCC);
        @(negedge clock);
        send_byte(8'hDD);
        total++; if ({mem_write, in_ready} !== 2'b10) begin bad++; $display("FAIL stall_write: got %b required 10", {mem_write, in_ready}); end
        total++; if (mem_addr !== 10'h000) begin bad++; $display("FAIL stall_addr: got %h required 000", mem_addr); end
        total++; if (mem_data !== 32'hDDCCBBAA) begin bad++; $display("FAIL stall_data: got %h required ddccbbaa", mem_data); end
        @(negedge clock);
        total++; if (done !== 1'b1) begin bad++; $display("FAIL stall_done: got %b required 1", done); end
        total++; if (wr_n - w0 !== 1) begin bad++; $display("FAIL stall_write_count: got %0d required 1", wr_n - w0); end
    endtask

    task automatic test_reset_mid;
        int w0;
        pulse_start;
        send_byte(8'h03);
        send_byte(8'h00);
        send_byte(8'h11);
        send_byte(8'h22);
        w0 = wr_n;
        reset = 1'b0;
        @(negedge clock);
        total++; if ({in_ready, mem_write, cpu_hold, busy, done, error} !== 6'd0) begin bad++; $display("FAIL rstmid_flags: got %b required 000000", {in_ready, mem_write, cpu_hold, busy, done, error}); end
        total++; if (mem_addr !== '0) begin bad++; $display("FAIL rstmid_addr: got %h required 0", mem_addr); end
        total++; if (mem_data !== 32'd0) begin bad++; $display("FAIL rstmid_data: got %h required 0", mem_data); end
        reset = 1'b1;
        repeat (2) @(negedge clock);
        total++; if (wr_n - w0 !== 0) begin bad++; $display("FAIL rstmid_no_write: got %0d required 0", wr_n - w0); end
        pulse_start;
        send_byte(8'h01);
        send_byte(8'h00);
        send_word(32'h11223344);
        total++; if (mem_write !== 1'b1) begin bad++; $display("FAIL rstmid_fresh_strobe: got %b required 1", mem_write); end
        total++; if (mem_addr !== 10'h000) begin bad++; $display("FAIL rstmid_fresh_addr: got %h required 000", mem_addr); end
        total++; if (mem_data !== 32'h11223344) begin bad++; $display("FAIL rstmid_fresh_data: got %h required 11223344", mem_data); end
        @(negedge clock);
        total++; if (done !== 1'b1) begin bad++; $display("FAIL rstmid_fresh_done: got %b required 1", done); end
    endtask

    task automatic test_full;
        int w0;
        logic [31:0] w;
        w0 = wr_n;
        pulse_start;
        send_byte(8'h00);
        send_byte(8'h04);
        total++; if ({error, busy} !== 2'b01) begin bad++; $display("FAIL full_len_ok: got %b required 01", {error, busy}); end
        for (int i = 0; i < 1024; i++) begin
            w = 32'h5A000000 | 32'(i);
            send_word(w);
            total++; if ({mem_write, mem_addr} !== {1'b1, ADDR_W'(i)}) begin bad++; $display("FAIL full_addr: got wr=%b addr=%h required wr=1 addr=%h", mem_write, mem_addr, ADDR_W'(i)); end
            total++; if (mem_data !== w) begin bad++; $display("FAIL full_data: got %h required %h", mem_data, w); end
        end
        @(negedge clock);
        total++; if ({done, cpu_hold, busy} !== 3'b100) begin bad++; $display("FAIL full_done: got %b required 100", {done, cpu_hold, busy}); end
        total++; if (wr_n - w0 !== 1024) begin bad++; $display("FAIL full_write_count: got %0d required 1024", wr_n - w0); end
        total++; if (wr_last_addr !== 10'h3FF) begin bad++; $display("FAIL full_last_addr: got %h required 3ff", wr_last_addr); end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_zero_len;
        test_overflow;
        test_stall;
        test_reset_mid;
        test_full;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 Parameter ADDR_W, default 10, instruction-memory word-address width; capacity 2^ADDR_W words.
REQ-002 clock  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-low; reset==0 at a rising edge resets the block.
REQ-004 start  input  1  one-cycle request to begin a load frame.
REQ-005 in_data  input  8  byte stream from host.
REQ-006 in_valid  input  1  in_data valid.
REQ-007 in_ready  output  1  block accepts a byte; transfer occurs when in_valid & in_ready at a rising edge.
REQ-008 mem_addr  output  ADDR_W  instruction-memory word address.
REQ-009 mem_data  output  32  instruction word to write.
REQ-010 mem_write  output  1  write strobe, one cycle per word.
REQ-011 cpu_hold  output  1  holds the CPU (PC and control-unit state) while a load is in progress or failed.
REQ-012 busy  output  1  high in LEN_LO, LEN_HI, DATA, WRITE.
REQ-013 done  output  1  level, high in DONE.
REQ-014 error  output  1  level, high in ERR.

Function
REQ-015 Frame format: 2-byte word count N (little-endian: low byte first), then 4*N bytes; each word is little-endian (first byte -> bits [7:0], fourth -> [31:24]).
REQ-016 States SHALL be IDLE, LEN_LO, LEN_HI, DATA, WRITE, DONE, ERR.
REQ-017 start is honoured only in IDLE, DONE, ERR -> LEN_LO next cycle, clearing word address, byte counter, done, error; start SHALL be ignored in LEN_LO, LEN_HI, DATA, WRITE.
REQ-018 in_ready SHALL be 1 exactly in LEN_LO, LEN_HI, DATA; 0 in IDLE, WRITE, DONE, ERR; bytes offered while in_ready=0 are not consumed.
REQ-019 LEN_LO: on handshake latch N[7:0] -> LEN_HI. LEN_HI: on handshake latch N[15:8]; N==0 -> DONE; N > 2^ADDR_W -> ERR; else -> DATA.
REQ-020 DATA: each handshake stores byte into lane given by 2-bit byte counter and increments it; on fourth byte (counter 3) -> WRITE, counter wraps to 0.
REQ-021 WRITE lasts exactly one cycle: mem_write=1, mem_addr=current word address, mem_data=assembled word; next cycle word address +1; if words written == N -> DONE, else -> DATA.
REQ-022 Latency: mem_write asserts the cycle after the fourth byte handshake; sustained throughput 4 bytes per 5 cycles.
REQ-023 mem_write SHALL be 0 in every state except WRITE; mem_addr/mem_data hold last written values otherwise.
REQ-024 N == 2^ADDR_W writes addresses 0..2^ADDR_W-1 with no address wrap; word address never exceeds 2^ADDR_W-1 at a write.
REQ-025 cpu_hold SHALL be 1 in LEN_LO, LEN_HI, DATA, WRITE, ERR; 0 in IDLE and DONE.
REQ-026 DONE and ERR persist until start or reset.
REQ-027 Host stalls (in_valid low) in any receive state SHALL leave all state unchanged; no timeout.

Reset
REQ-028 On reset==0: state IDLE, in_ready=0, mem_write=0, mem_addr=0, mem_data=0, cpu_hold=0, busy=0, done=0, error=0, byte counter 0, word address 0, N=0.
REQ-029 Reset mid-frame discards the partial word and frame; no mem_write in the reset cycle or after; next start loads from address 0.
REQ-030 reset==0 overrides start in the same cycle.

Verification
REQ-031 start; bytes 02 00 13 00 00 91 00 00 1F D6 back-to-back -> write addr0=0x91000013, addr1=0xD61F0000, each one cycle after 4th byte; then done=1, cpu_hold=0, busy=0.
REQ-032 start; bytes 00 00 -> DONE cycle after second byte, no mem_write, cpu_hold 1 during LEN states then 0.
REQ-033 ADDR_W=10; start; bytes 01 04 (N=1025) -> error=1, cpu_hold=1, in_ready=0, no writes; later start -> LEN_LO, error=0.
REQ-034 N=1 with in_valid toggling every other cycle, start pulsed during DATA -> start ignored, exactly one write of correct word; in_ready=0 during WRITE cycle.
REQ-035 reset=0 after 2 DATA bytes of N=3 -> all outputs per REQ-028; fresh frame N=1 writes to addr0.
REQ-036 N=1024 (ADDR_W=10) full load -> last write addr 0x3FF, exactly 1024 mem_write pulses, done=1.
